// File: rtl/double_dabble_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package double_dabble_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } dd_state_t;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/dabble_digit.sv
// One BCD digit correction: add 3 (mod 16) when the digit is 5 or more.
module dabble_digit
    import double_dabble_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/double_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define DOUBLE_DABBLE_SIGNED_EN for two's-complement input with a sign output.
module double_dabble_seq
    import double_dabble_pkg::*;
#(
    parameter int BIN_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*BCD_DIGITS-1:0] bcd_out,
`ifdef DOUBLE_DABBLE_SIGNED_EN
    output logic                          sign,
`endif
    output logic                          overflow
);

    localparam int BCD_W = DIGIT_W * BCD_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    dd_state_t          state;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BIN_W-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_scr;
    logic [BIN_W-1:0]   operand;

`ifdef DOUBLE_DABBLE_SIGNED_EN
    // BIN_W-bit unsigned magnitude, so the most negative value maps to 2^(BIN_W-1).
    function automatic logic [BIN_W-1:0] magnitude(input logic signed [BIN_W-1:0] v);
        return v[BIN_W-1] ? (~v + BIN_W'(1)) : v;
    endfunction

    assign operand = magnitude(bin_in);
`else
    assign operand = bin_in;
`endif

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        dabble_digit u_digit (
            .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
            .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
            scratch  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            ovf_scr  <= 1'b0;
`ifdef DOUBLE_DABBLE_SIGNED_EN
            sign     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= operand;
                        scratch <= '0;
                        ovf_scr <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef DOUBLE_DABBLE_SIGNED_EN
                        sign    <= bin_in[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    // Corrected digits shift left with the next operand bit entering at the bottom.
                    scratch <= {scratch_adj[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    ovf_scr <= ovf_scr | scratch_adj[BCD_W-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out  <= scratch;
                    overflow <= ovf_scr;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/double_dabble_seq.md
DOUBLE_DABBLE_SEQ -- requirements
Module: double_dabble_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8: binary input width (legal range 4..32).
REQ-002 SHALL have parameter BCD_DIGITS, default 3: number of BCD output digits (legal range 1..10).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request a conversion of bin_in.
REQ-006 SHALL have port bin_in, input, BIN_W bits: binary operand, sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when bcd_out is updated.
REQ-009 SHALL have port bcd_out, output, 4*BCD_DIGITS bits: packed BCD result, with digit 0 (units) in bits [3:0].
REQ-010 SHALL have port overflow, output, 1 bit: result exceeded BCD_DIGITS digits; valid with done.
REQ-011 SHALL have one clock and synchronous active-high reset; the clock port is clk and the reset port is rst.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: start=1 is accepted; the FSM latches bin_in into the shift register, clears the BCD scratch register and the overflow scratch, loads iteration counter = BIN_W, and moves to SHIFT.
REQ-014 SHIFT, each cycle:
- Every scratch digit >= 5 gets +3 (mod 16).
- Then {scratch, shreg} shifts left by 1.
- Any nonzero bit shifted out of the top digit sets the overflow scratch.
- The counter decrements.
- The FSM moves to DONE when the counter reaches 1 before the decrement, i.e. exactly BIN_W shift cycles.
REQ-015 DONE: bcd_out <= scratch, overflow <= overflow scratch, done=1 for exactly this cycle, and the next state is IDLE.
REQ-016 Latency: start accepted at edge N gives done high in the cycle following edge N+BIN_W+1, for BIN_W+2 cycles start-to-done inclusive; throughput is one conversion per BIN_W+2 cycles.
REQ-017 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-018 start while busy=1 (including in DONE) is ignored and not queued; bin_in changes during a conversion have no effect.
REQ-019 bcd_out and overflow hold their values between done pulses.
REQ-020 BCD digits never exceed 9 in bcd_out when overflow=0; when overflow=1, bcd_out holds the low BCD_DIGITS digits of the true result.
REQ-021 Counter width SHALL be clog2(BIN_W+1) bits; there is no wrap-around.

Reset
REQ-022 rst=1 at any edge, including mid-conversion, forces the following: state IDLE, busy=0, done=0, overflow=0, bcd_out=0, scratch, shreg and counter = 0.
REQ-023 A conversion interrupted by reset produces no done pulse; start in the same cycle as rst is ignored.

Configuration
REQ-024 With macro DOUBLE_DABBLE_SIGNED_EN defined:
- bin_in is two's complement.
- An added output sign (1 bit) is latched on an accepted start as bin_in[BIN_W-1].
- The magnitude |bin_in| (BIN_W-bit unsigned, so -2^(BIN_W-1) converts correctly) is converted.
- sign resets to 0 and updates only at acceptance.
REQ-025 Without DOUBLE_DABBLE_SIGNED_EN: bin_in is unsigned, there is no sign port, and the behaviour is as above.

Structure
REQ-026 Shared package double_dabble_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE), the BCD digit width constant (4), and the add-3 threshold constant (5).
REQ-027 One sub-module, dabble_digit, SHALL implement the combinational 4-bit add-3-if->=5 correction; it is instantiated BCD_DIGITS times via generate.

Verification
REQ-028 Defaults: bin_in=255, start pulse -> done exactly BIN_W+2=10 cycles later inclusive, with bcd_out=0x255 and overflow=0.
REQ-029 Defaults: bin_in=0 -> bcd_out=0x000, then bin_in=99 -> bcd_out=0x099, with back-to-back starts issued on the first cycle busy=0.
REQ-030 start re-pulsed with bin_in=7 during SHIFT and during DONE -> ignored; the result remains the first operand, and only one done pulse occurs.
REQ-031 rst asserted in the 4th SHIFT cycle -> next cycle busy=0, bcd_out=0, and no done; a fresh start with 42 -> 0x042.
REQ-032 BCD_DIGITS=2, bin_in=255 -> overflow=1 and bcd_out=0x55; bin_in=99 -> overflow=0 and bcd_out=0x99.
REQ-033 DOUBLE_DABBLE_SIGNED_EN defined: bin_in=8'h80 -> sign=1, bcd_out=0x128; bin_in=8'h7F -> sign=0, bcd_out=0x127.
